dmem_arbiter: RTL and testbench

Shares the single-port data RAM between the pipeline's Memory stage and an external host port (program/data loader, debug reader). The pipeline normally has priority; a saturating wait counter guarantees the host a slot after MAX_WAIT consecutive denied cycles, and the pipeline is stalled for that cycle. The block sits between the Execute-Memory register outputs and the RAM instance, and returns read data to both requesters with a registered owner tag matching the RAM's 1-cycle read latency.

---
 rtl/dmem_arbiter.sv | 94 +++++++++
 tb/tb_dmem_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Data RAM arbiter: Memory-stage pipeline port vs. host loader/debug port.
// The pipeline has priority; a saturating wait counter forces a host slot after MAX_WAIT denials.
module dmem_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_HOST = 2'd2
  } owner_t;

  localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

  logic [3:0] wait_cnt;
  owner_t     rd_owner;
  logic       host_win;
  logic       cpu_win;

  // Grant decision and RAM mux: combinational, same cycle as the request
  always_comb begin
    host_win    = host_req & (~cpu_req | (wait_cnt >= WAIT_LIMIT));
    cpu_win     = cpu_req & ~host_win;
    ram_address = '0;
    ram_data    = '0;
    ram_wren    = 1'b0;
    if (host_win) begin
      ram_address = host_addr;
      ram_data    = host_wdata;
      ram_wren    = host_we;
    end else if (cpu_win) begin
      ram_address = cpu_addr;
      ram_data    = cpu_wdata;
      ram_wren    = cpu_we;
    end
    if (reset) begin
      ram_wren = 1'b0;
    end
  end

  assign cpu_stall = cpu_req & ~cpu_win;
  assign host_gnt  = host_win;

  // Registered stage: starvation counter and read-response owner tag
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= 4'd0;
      rd_owner <= OWN_NONE;
    end else begin
      if (host_req & ~host_win) begin
        wait_cnt <= (wait_cnt >= WAIT_LIMIT) ? WAIT_LIMIT : wait_cnt + 4'd1;
      end else begin
        wait_cnt <= 4'd0;
      end
      if (host_win & ~host_we) begin
        rd_owner <= OWN_HOST;
      end else if (cpu_win & ~cpu_we) begin
        rd_owner <= OWN_CPU;
      end else begin
        rd_owner <= OWN_NONE;
      end
    end
  end

  // Response stage: the tag lines up with the RAM's one-cycle read latency
  assign cpu_rvalid  = (rd_owner == OWN_CPU) & ~reset;
  assign host_rvalid = (rd_owner == OWN_HOST) & ~reset;
  assign cpu_rdata   = ram_q;
  assign host_rdata  = ram_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: RAM model, shadow-memory reference model with a per-cycle
// compare process, directed literal checks and a randomized contention phase.
module tb_dmem_arbiter;

  localparam int ADDR_W   = 16;
  localparam int DATA_W   = 16;
  localparam int MAX_WAIT = 4;

  logic              clk;
  logic              reset;
  logic              cpu_req, cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_stall, cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;
  logic              host_req, host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_gnt, host_rvalid;
  logic [DATA_W-1:0] host_rdata;
  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_data;
  logic              ram_wren;
  logic [DATA_W-1:0] ram_q;

  int checks = 0;
  int errors = 0;

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM with one-cycle registered read
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
    ram_q = '0;
  end
  always @(posedge clk) begin
    if (ram_wren) mem[ram_address] <= ram_data;
    ram_q <= mem[ram_address];
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: consecutive host denials, shadow memory, and the one pending read
  logic [DATA_W-1:0] shadow [int];
  int                streak   = 0;
  int                pend_own = 0;   // 0 none, 1 cpu, 2 host
  logic [DATA_W-1:0] pend_data = '0;

  function automatic logic [DATA_W-1:0] shadow_rd(input logic [ADDR_W-1:0] a);
    return shadow.exists(int'(a)) ? shadow[int'(a)] : '0;
  endfunction

  always @(negedge clk) begin
    bit                hw, cw, ewe, is_rd;
    logic [ADDR_W-1:0] ea;
    logic [DATA_W-1:0] ed;
    hw  = host_req && (!cpu_req || streak >= MAX_WAIT);
    cw  = cpu_req && !hw;
    ea  = hw ? host_addr  : (cw ? cpu_addr  : '0);
    ed  = hw ? host_wdata : (cw ? cpu_wdata : '0);
    ewe = hw ? host_we    : (cw ? cpu_we    : 1'b0);
    chk("cpu_stall", cpu_stall, cpu_req && !cw);
    chk("host_gnt", host_gnt, hw);
    chk("ram_address", ram_address, ea);
    chk("ram_data", ram_data, ed);
    chk("ram_wren", ram_wren, ewe && !reset);
    chk("cpu_rvalid", cpu_rvalid, !reset && pend_own == 1);
    chk("host_rvalid", host_rvalid, !reset && pend_own == 2);
    if (!reset && pend_own == 1) chk("cpu_rdata", cpu_rdata, pend_data);
    if (!reset && pend_own == 2) chk("host_rdata", host_rdata, pend_data);
    if (reset) begin
      streak   = 0;
      pend_own = 0;
    end else begin
      is_rd     = (hw || cw) && !ewe;
      pend_own  = is_rd ? (hw ? 2 : 1) : 0;
      pend_data = shadow_rd(ea);
      if ((hw || cw) && ewe) shadow[int'(ea)] = ed;
      streak = (host_req && !hw) ? streak + 1 : 0;
    end
  end

  task automatic set_in(input bit cr, input bit cwe, input logic [15:0] ca, input logic [15:0] cd,
                        input bit hr, input bit hwe, input logic [15:0] ha, input logic [15:0] hd);
    cpu_req = cr; cpu_we = cwe; cpu_addr = ca; cpu_wdata = cd;
    host_req = hr; host_we = hwe; host_addr = ha; host_wdata = hd;
  endtask

  task automatic mid();
    @(negedge clk); #1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    set_in(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
  endtask

  initial begin
    bit                hr, hwe, g;
    logic [ADDR_W-1:0] ha;
    logic [DATA_W-1:0] hd;

    // Reset held two cycles with both ports requesting
    reset = 1'b1;
    set_in(1, 1, 16'h0003, 16'h1111, 1, 1, 16'h0005, 16'h2222);
    repeat (2) begin
      mid();
      chk("rst_wren", ram_wren, 1'b0);
      chk("rst_cpu_rvalid", cpu_rvalid, 1'b0);
      chk("rst_host_rvalid", host_rvalid, 1'b0);
      tick();
    end
    reset = 1'b0;
    set_in(1, 0, 16'h0003, 16'h0, 1, 0, 16'h0005, 16'h0);
    mid();
    chk("post_rst_cpu_first", cpu_stall, 1'b0);
    chk("post_rst_host_wait", host_gnt, 1'b0);
    tick();
    idle(); tick();

    // CPU write then read back
    set_in(1, 1, 16'h0010, 16'hBEEF, 0, 0, 16'h0, 16'h0);
    mid(); chk("cpu_wr_stall", cpu_stall, 1'b0); chk("cpu_wr_wren", ram_wren, 1'b1); tick();
    set_in(1, 0, 16'h0010, 16'h0, 0, 0, 16'h0, 16'h0);
    mid(); chk("cpu_rd_stall", cpu_stall, 1'b0); tick();
    idle();
    mid(); chk("cpu_rd_valid", cpu_rvalid, 1'b1); chk("cpu_rd_data", cpu_rdata, 16'hBEEF); tick();

    // Host-only write then read back
    set_in(0, 0, 16'h0, 16'h0, 1, 1, 16'h0020, 16'h1234);
    mid(); chk("host_wr_gnt", host_gnt, 1'b1); tick();
    set_in(0, 0, 16'h0, 16'h0, 1, 0, 16'h0020, 16'h0);
    mid(); chk("host_rd_gnt", host_gnt, 1'b1); tick();
    idle();
    mid(); chk("host_rd_valid", host_rvalid, 1'b1); chk("host_rd_data", host_rdata, 16'h1234); tick();

    // Sustained contention: host forced in every fifth cycle
    set_in(1, 0, 16'h0010, 16'h0, 1, 0, 16'h0020, 16'h0);
    for (int k = 0; k < 10; k++) begin
      mid();
      chk("cont_host_gnt", host_gnt, (k % 5) == 4);
      chk("cont_cpu_stall", cpu_stall, (k % 5) == 4);
      tick();
    end
    idle(); tick();

    // Host withdraws after three denials and re-requests: counter restarts
    set_in(1, 0, 16'h0010, 16'h0, 1, 0, 16'h0020, 16'h0);
    for (int k = 0; k < 3; k++) begin
      mid(); chk("wd_pre_gnt", host_gnt, 1'b0); tick();
    end
    host_req = 1'b0;
    mid(); chk("wd_drop_gnt", host_gnt, 1'b0); chk("wd_drop_stall", cpu_stall, 1'b0); tick();
    host_req = 1'b1;
    for (int r = 0; r < 5; r++) begin
      mid(); chk("wd_re_gnt", host_gnt, r == 4); tick();
    end
    idle(); tick();

    // Interleaved reads return in grant order
    set_in(1, 1, 16'h0001, 16'h00AA, 0, 0, 16'h0, 16'h0); tick();
    set_in(1, 1, 16'h0002, 16'h00BB, 0, 0, 16'h0, 16'h0); tick();
    set_in(1, 0, 16'h0001, 16'h0, 0, 0, 16'h0, 16'h0); tick();
    set_in(0, 0, 16'h0, 16'h0, 1, 0, 16'h0002, 16'h0);
    mid();
    chk("il_cpu_valid", cpu_rvalid, 1'b1);
    chk("il_cpu_data", cpu_rdata, 16'h00AA);
    chk("il_host_gnt", host_gnt, 1'b1);
    tick();
    idle();
    mid();
    chk("il_host_valid", host_rvalid, 1'b1);
    chk("il_host_data", host_rdata, 16'h00BB);
    chk("il_cpu_quiet", cpu_rvalid, 1'b0);
    tick();

    // Reset arriving while a read is outstanding kills the response
    set_in(1, 0, 16'h0001, 16'h0, 0, 0, 16'h0, 16'h0); tick();
    idle(); reset = 1'b1;
    mid(); chk("rp_rst_cycle", cpu_rvalid, 1'b0); tick();
    reset = 1'b0;
    mid(); chk("rp_after_cpu", cpu_rvalid, 1'b0); chk("rp_after_host", host_rvalid, 1'b0); tick();

    // Randomized traffic: host holds its request until granted or withdrawn
    hr = 0; hwe = 0; ha = '0; hd = '0; g = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hr && !g) begin
        if ($urandom_range(9) == 0) hr = 0;
      end else begin
        hr  = ($urandom_range(1) == 1);
        hwe = ($urandom_range(1) == 1);
        ha  = 16'($urandom_range(15));
        hd  = 16'($urandom);
      end
      set_in($urandom_range(3) != 0, $urandom_range(1) == 1, 16'($urandom_range(15)), 16'($urandom),
             hr, hwe, ha, hd);
      reset = ($urandom_range(99) == 0);
      mid();
      g = host_gnt;
      tick();
    end
    reset = 1'b0;
    idle();
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
